mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 16, address width of all ports.
REQ-002 Parameter DATA_W, 16, data width of all ports.
REQ-003 Parameter TIMEOUT, 255, maximum cycles spent in ISSUE+WAIT before abort; 0 disables the timeout.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 f_req  in  1  fetch port read request, held until f_done.
REQ-007 f_addr  in  ADDR_W  fetch address, stable while f_req=1.
REQ-008 f_done  out  1  one-cycle completion pulse to fetch port.
REQ-009 f_rdata  out  DATA_W  fetch read data, valid only while f_done=1.
REQ-010 f_err  out  1  fetch timeout flag, asserted only together with f_done.
REQ-011 d_req  in  1  data port request, held until d_done.
REQ-012 d_we, d_addr, d_wdata  in  1/ADDR_W/DATA_W  data write enable, address and write data, stable while d_req=1.
REQ-013 d_done, d_rdata, d_err  out  1/DATA_W/1  same semantics as the fetch outputs; d_rdata is undefined for writes.
REQ-014 m_read, m_write  out  1  registered memory commands; at most one is high at a time.
REQ-015 m_instr  out  1  high while the fetch port owns the bus.
REQ-016 m_addr, m_wdata  out  ADDR_W/DATA_W  latched command address and write data.
REQ-017 m_busy, m_cack, m_ready  in  1  memory busy, command accepted, and transfer complete (read data valid).
REQ-018 m_rdata  in  DATA_W  memory read data, sampled on m_ready.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT and DONE.
REQ-020 IDLE: when m_busy=0 and any request is high, the block SHALL grant one port, latch its addr/we/wdata and enter ISSUE on the next edge; m_busy=1 holds IDLE.
REQ-021 With both requests high, the port not granted last SHALL win (round-robin); a single requester always wins.
REQ-022 ISSUE: m_read or m_write SHALL be held with latched m_addr/m_wdata until m_cack=1, then enter WAIT.
REQ-023 m_cack=1 and m_ready=1 in the same ISSUE cycle SHALL go directly to DONE.
REQ-024 WAIT: commands SHALL be deasserted; on m_ready=1, m_rdata SHALL be latched and the FSM SHALL enter DONE.
REQ-025 DONE: the granted port's done SHALL be high for exactly one cycle with latched rdata; the grant history SHALL update; next state is IDLE.
REQ-026 Requests SHALL be sampled only in IDLE, so a request still high during DONE is re-arbitrated in the following IDLE cycle.
REQ-027 Minimum latency SHALL be 3 cycles from req to done (cack+ready in the first ISSUE cycle); 4 cycles if ready arrives one cycle after cack.
REQ-028 The timeout counter SHALL clear on entering ISSUE and increment each ISSUE/WAIT cycle; reaching TIMEOUT SHALL force DONE with err=1, rdata=0, commands dropped.
REQ-029 Outputs of the non-granted port SHALL stay 0; done, err and commands SHALL never be X after reset.

Reset
REQ-030 rst=1 SHALL force IDLE, all outputs 0, counter 0 and last-grant=fetch, so data wins the first tie.
REQ-031 A reset mid-transaction SHALL abandon the transfer with no done pulse; requesters reissue.

Structure
REQ-032 State encodings, port-id constants (PORT_F=0, PORT_D=1) and the default TIMEOUT SHALL reside in the shared header mem_arb_defs.vh.
REQ-033 The timeout counter SHALL be a sub-module, mem_timeout (clear, enable, expired).

Verification
REQ-034 d_req write 0x1234 to addr 0x0040, cack cycle 1, ready cycle 2 -> m_write=1 with m_addr=0x0040 and m_wdata=0x1234 in cycle 1; d_done cycle 3; d_err=0.
REQ-035 f_req and d_req both high from reset, each re-raised after done -> grants d,f,d,f; m_instr=1 only during fetch grants.
REQ-036 f_req addr 0x0100, cack delayed 5 cycles, m_rdata=0xBEEF with ready -> m_read held 5 cycles; f_rdata=0xBEEF with f_done.
REQ-037 TIMEOUT=8, m_cack never asserted -> f_done=1, f_err=1, f_rdata=0 after 8 ISSUE cycles; FSM returns to IDLE.
REQ-038 rst pulsed during WAIT, then m_ready=1 -> no done pulse, all outputs 0, next request served normally.
REQ-039 m_busy=1 for 10 cycles with d_req high -> no command until m_busy falls; m_write asserted the cycle after.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM states, port ids
// and the default abort limit.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    localparam logic PORT_F = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/mem_timeout.sv
// Transaction watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the TIMEOUT-th enabled cycle is reached.
module mem_timeout
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // The count saturates at LIMIT so a lingering enable cannot wrap it.
    assign expired = enable && (TIMEOUT != 0) && (count == LIMIT);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory command port between an instruction
// fetch port and a data port, with an optional per-transaction abort timeout.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_done,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              m_read,
    output logic              m_write,
    output logic              m_instr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_busy,
    input  logic              m_cack,
    input  logic              m_ready,
    input  logic [DATA_W-1:0] m_rdata
);

    arb_state_t        state;
    logic              grant;
    logic              last_grant;
    logic              start;
    logic              pick;
    logic              tmo_expired;
    logic              go_done;
    logic              go_err;
    logic [DATA_W-1:0] go_data;

    assign start = !m_busy && (f_req || d_req);

    mem_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clear   (state == ST_IDLE),
        .enable  ((state == ST_ISSUE) || (state == ST_WAIT)),
        .expired (tmo_expired)
    );

    // On a tie the port that did not win last time takes the bus.
    always_comb begin
        pick = PORT_F;
        if (f_req && d_req) begin
            pick = ~last_grant;
        end else if (d_req) begin
            pick = PORT_D;
        end
    end

    // A genuine completion beats an abort landing in the same cycle.
    always_comb begin
        go_done = 1'b0;
        go_err  = 1'b0;
        go_data = '0;
        case (state)
            ST_ISSUE: begin
                if (m_cack && m_ready) begin
                    go_done = 1'b1;
                    go_data = m_rdata;
                end else if (tmo_expired) begin
                    go_done = 1'b1;
                    go_err  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (m_ready) begin
                    go_done = 1'b1;
                    go_data = m_rdata;
                end else if (tmo_expired) begin
                    go_done = 1'b1;
                    go_err  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            grant      <= PORT_F;
            last_grant <= PORT_F;
            m_read     <= 1'b0;
            m_write    <= 1'b0;
            m_instr    <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            f_done     <= 1'b0;
            f_err      <= 1'b0;
            f_rdata    <= '0;
            d_done     <= 1'b0;
            d_err      <= 1'b0;
            d_rdata    <= '0;
        end else begin
            f_done  <= go_done && (grant == PORT_F);
            f_err   <= go_err  && (grant == PORT_F);
            f_rdata <= (go_done && (grant == PORT_F)) ? go_data : '0;
            d_done  <= go_done && (grant == PORT_D);
            d_err   <= go_err  && (grant == PORT_D);
            d_rdata <= (go_done && (grant == PORT_D)) ? go_data : '0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        grant   <= pick;
                        m_addr  <= (pick == PORT_D) ? d_addr : f_addr;
                        m_wdata <= (pick == PORT_D && d_we) ? d_wdata : '0;
                        m_read  <= (pick == PORT_F) || !d_we;
                        m_write <= (pick == PORT_D) && d_we;
                        m_instr <= (pick == PORT_F);
                        state   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (go_done || m_cack) begin
                        m_read  <= 1'b0;
                        m_write <= 1'b0;
                        state   <= go_done ? ST_DONE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (go_done) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    last_grant <= grant;
                    m_instr    <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, write/read timing, round-robin,
// delayed accept, abort timeout, mid-transfer reset and busy back-pressure.
module tb_mem_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_done;
    logic [DATA_W-1:0] f_rdata;
    logic              f_err;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;
    logic              m_read;
    logic              m_write;
    logic              m_instr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_busy;
    logic              m_cack;
    logic              m_ready;
    logic [DATA_W-1:0] m_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata), .f_err(f_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .m_read(m_read), .m_write(m_write), .m_instr(m_instr),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_busy(m_busy), .m_cack(m_cack), .m_ready(m_ready), .m_rdata(m_rdata)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        f_req = 1'b0; f_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        m_busy = 1'b0; m_cack = 1'b0; m_ready = 1'b0; m_rdata = '0;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if ({f_done, f_err, d_done, d_err, m_read, m_write, m_instr} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, want 0000000",
                     {f_done, f_err, d_done, d_err, m_read, m_write, m_instr});
        end
        checks++;
        if ({m_addr, m_wdata, f_rdata, d_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h, want 0", {m_addr, m_wdata, f_rdata, d_rdata});
        end
    endtask

    task automatic test_write;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0040; d_wdata = 16'h1234;
        tick;
        checks++;
        if ({m_write, m_read, m_instr, m_addr, m_wdata} !== {3'b100, 16'h0040, 16'h1234}) begin
            errors++;
            $display("FAIL write_issue: got w=%b r=%b i=%b a=%h d=%h, want w=1 r=0 i=0 a=0040 d=1234",
                     m_write, m_read, m_instr, m_addr, m_wdata);
        end
        m_cack = 1'b1;
        tick;
        m_cack = 1'b0;
        checks++;
        if ({m_write, d_done} !== 2'b00) begin
            errors++;
            $display("FAIL write_wait: got w=%b done=%b, want 0 0", m_write, d_done);
        end
        m_ready = 1'b1;
        tick;
        m_ready = 1'b0;
        checks++;
        if ({d_done, d_err, f_done} !== 3'b100) begin
            errors++;
            $display("FAIL write_done: got d_done=%b d_err=%b f_done=%b, want 1 0 0", d_done, d_err, f_done);
        end
        d_req = 1'b0;
        tick;
        checks++;
        if (d_done !== 1'b0) begin
            errors++;
            $display("FAIL write_done_pulse: got %b, want 0", d_done);
        end
    endtask

    task automatic test_round_robin;
        logic exp_port [4];
        exp_port[0] = 1'b1; exp_port[1] = 1'b0; exp_port[2] = 1'b1; exp_port[3] = 1'b0;
        do_reset;
        f_addr = 16'h0200; d_addr = 16'h0300; d_we = 1'b0;
        f_req = 1'b1; d_req = 1'b1;
        for (int t = 0; t < 4; t++) begin
            int n;
            n = 0;
            tick;
            while (!(m_read || m_write) && n < 20) begin
                tick;
                n++;
            end
            checks++;
            if (n >= 20) begin
                errors++;
                $display("FAIL rr_grant_%0d: no command within 20 cycles, want a command", t);
            end
            checks++;
            if ({m_instr, m_addr} !== (exp_port[t] ? {1'b0, 16'h0300} : {1'b1, 16'h0200})) begin
                errors++;
                $display("FAIL rr_owner_%0d: got instr=%b addr=%h, want instr=%b addr=%h", t,
                         m_instr, m_addr, !exp_port[t], exp_port[t] ? 16'h0300 : 16'h0200);
            end
            m_cack = 1'b1; m_ready = 1'b1; m_rdata = 16'hA000 + 16'(t);
            tick;
            m_cack = 1'b0; m_ready = 1'b0;
            checks++;
            if ({d_done, f_done} !== {exp_port[t], !exp_port[t]}) begin
                errors++;
                $display("FAIL rr_done_%0d: got d=%b f=%b, want d=%b f=%b", t,
                         d_done, f_done, exp_port[t], !exp_port[t]);
            end
            checks++;
            if ((exp_port[t] ? d_rdata : f_rdata) !== 16'hA000 + 16'(t)) begin
                errors++;
                $display("FAIL rr_rdata_%0d: got %h, want %h", t,
                         exp_port[t] ? d_rdata : f_rdata, 16'hA000 + 16'(t));
            end
            // Requester drops for the DONE cycle and re-raises in the next IDLE.
            if (exp_port[t]) d_req = 1'b0; else f_req = 1'b0;
            tick;
            f_req = 1'b1; d_req = 1'b1;
            #0;
            // Back up one cycle of the loop's leading tick by not ticking again here.
            if (t == 3) begin
                f_req = 1'b0; d_req = 1'b0;
            end
            else begin
                // Next iteration's first tick moves IDLE into ISSUE.
            end
        end
        tick;
    endtask

    task automatic test_delayed_cack;
        int n;
        f_req = 1'b1; f_addr = 16'h0100; m_rdata = 16'h0000;
        tick;
        n = 0;
        while (m_read && n < 20) begin
            n++;
            if (m_addr !== 16'h0100 || m_instr !== 1'b1) n = 100;
            if (n == 5) m_cack = 1'b1;
            tick;
            m_cack = 1'b0;
        end
        checks++;
        if (n !== 5) begin
            errors++;
            $display("FAIL dly_read_cycles: got %0d, want 5", n);
        end
        m_ready = 1'b1; m_rdata = 16'hBEEF;
        tick;
        m_ready = 1'b0;
        checks++;
        if ({f_done, f_err, d_done, f_rdata} !== {3'b100, 16'hBEEF}) begin
            errors++;
            $display("FAIL dly_done: got done=%b err=%b d_done=%b rdata=%h, want 1 0 0 beef",
                     f_done, f_err, d_done, f_rdata);
        end
        f_req = 1'b0;
        tick;
    endtask

    task automatic test_timeout;
        int n;
        f_req = 1'b1; f_addr = 16'h0055; m_rdata = 16'hDEAD;
        tick;
        n = 0;
        while (!f_done && n < 30) begin
            if (m_read) n++;
            tick;
        end
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL tmo_issue_cycles: got %0d, want 8", n);
        end
        checks++;
        if ({f_done, f_err, m_read, f_rdata} !== {3'b110, 16'h0000}) begin
            errors++;
            $display("FAIL tmo_done: got done=%b err=%b m_read=%b rdata=%h, want 1 1 0 0000",
                     f_done, f_err, m_read, f_rdata);
        end
        f_req = 1'b0;
        tick;
        checks++;
        if ({f_done, f_err, m_read, m_write} !== 4'b0000) begin
            errors++;
            $display("FAIL tmo_idle: got %b, want 0000", {f_done, f_err, m_read, m_write});
        end
        m_rdata = '0;
    endtask

    task automatic test_reset_mid;
        int pulses;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0077;
        tick;
        m_cack = 1'b1;
        tick;
        m_cack = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0; d_req = 1'b0; m_ready = 1'b1; m_rdata = 16'h1111;
        checks++;
        if ({d_done, d_err, m_read, m_write, m_instr, m_addr, d_rdata} !== 37'h0) begin
            errors++;
            $display("FAIL rstmid_outputs: got done=%b read=%b addr=%h rdata=%h, want all 0",
                     d_done, m_read, m_addr, d_rdata);
        end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick;
            m_ready = 1'b0;
            if (d_done || f_done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL rstmid_no_done: got %0d pulses, want 0", pulses);
        end
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0088; d_wdata = 16'h5A5A;
        tick;
        checks++;
        if ({m_write, m_addr, m_wdata} !== {1'b1, 16'h0088, 16'h5A5A}) begin
            errors++;
            $display("FAIL rstmid_reissue: got w=%b a=%h d=%h, want 1 0088 5a5a", m_write, m_addr, m_wdata);
        end
        m_cack = 1'b1; m_ready = 1'b1;
        tick;
        m_cack = 1'b0; m_ready = 1'b0;
        checks++;
        if ({d_done, d_err} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_done: got done=%b err=%b, want 1 0", d_done, d_err);
        end
        d_req = 1'b0;
        tick;
    endtask

    task automatic test_busy;
        int cmds;
        m_busy = 1'b1;
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'h00A0; d_wdata = 16'hCAFE;
        cmds = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (m_read || m_write) cmds++;
        end
        checks++;
        if (cmds !== 0) begin
            errors++;
            $display("FAIL busy_hold: got %0d command cycles, want 0", cmds);
        end
        m_busy = 1'b0;
        tick;
        checks++;
        if ({m_write, m_read, m_addr, m_wdata} !== {2'b10, 16'h00A0, 16'hCAFE}) begin
            errors++;
            $display("FAIL busy_release: got w=%b r=%b a=%h d=%h, want 1 0 00a0 cafe",
                     m_write, m_read, m_addr, m_wdata);
        end
        m_cack = 1'b1; m_ready = 1'b1;
        tick;
        m_cack = 1'b0; m_ready = 1'b0;
        checks++;
        if (d_done !== 1'b1) begin
            errors++;
            $display("FAIL busy_done: got %b, want 1", d_done);
        end
        d_req = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_write;
        test_round_robin;
        test_delayed_cack;
        test_timeout;
        test_reset_mid;
        test_busy;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
